// File: rtl/game_fsm.sv
// Game-flow controller: IDLE -> ROUND_INTRO -> PLAY_GAME -> GAME_OVER, timed in video frames.
// Latency: every output is registered; a state change shows one cycle after the qualifying edge.
// Backpressure: none; inputs are sampled every cycle and the frame cadence paces all timed phases.
module game_fsm #(
    parameter int START_LIVES     = 3,
    parameter int NUM_ROUNDS      = 3,
    parameter int INTRO_FRAMES    = 120,
    parameter int INVULN_FRAMES   = 90,
    parameter int GAMEOVER_FRAMES = 180,
    parameter int NUM_ROWS        = 5,
    parameter int NUM_COLS        = 11
) (
    input  logic                                      pixel_clk,
    input  logic                                      rst,
    input  logic                                      fsync,
    input  logic                                      start_btn,
    input  logic                                      player_hit,
    input  logic                                      aliens_invaded,
    input  logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0]    aliens_remaining,
    output logic [1:0]                                game_state,
    output logic [1:0]                                current_round,
    output logic [1:0]                                lives_remaining,
    output logic                                      round_reset,
    output logic                                      invuln,
    output logic                                      game_won
);

    // Longest timed phase decides the shared counter width.
    localparam int MAX_A  = (INTRO_FRAMES > INVULN_FRAMES) ? INTRO_FRAMES : INVULN_FRAMES;
    localparam int MAX_F  = (MAX_A > GAMEOVER_FRAMES) ? MAX_A : GAMEOVER_FRAMES;
    localparam int FW     = $clog2(MAX_F + 1);

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        ROUND_INTRO = 2'b01,
        PLAY_GAME   = 2'b10,
        GAME_OVER   = 2'b11
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic            fsync_q;
    logic            start_q;
    logic            frame_tick;
    logic            start_edge;
    logic [FW-1:0]   frame_cnt_q;
    logic [FW-1:0]   frame_cnt_nxt;
    logic [FW-1:0]   frame_cnt_inc;
    logic [FW-1:0]   invuln_cnt_q;
    logic [FW-1:0]   invuln_cnt_nxt;
    logic [1:0]      round_nxt;
    logic [1:0]      lives_nxt;
    logic            round_reset_nxt;
    logic            invuln_nxt;
    logic            game_won_nxt;
    logic            hit_live;

    assign frame_tick    = fsync & ~fsync_q;
    assign start_edge    = start_btn & ~start_q;
    assign frame_cnt_inc = frame_cnt_q + FW'(1);
    assign game_state    = state_q;

    // Delay registers for rising-edge detection of fsync and start_btn.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            fsync_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            fsync_q <= fsync;
            start_q <= start_btn;
        end
    end

    // Next-state and next-output logic; every register holds unless a rule below changes it.
    always_comb begin
        state_nxt       = state_q;
        frame_cnt_nxt   = frame_cnt_q;
        invuln_cnt_nxt  = invuln_cnt_q;
        round_nxt       = current_round;
        lives_nxt       = lives_remaining;
        round_reset_nxt = 1'b0;
        invuln_nxt      = invuln;
        game_won_nxt    = game_won;
        hit_live        = player_hit & ~invuln;

        case (state_q)
            IDLE: begin
                // Game inputs are ignored here; only a fresh start press matters.
                if (start_edge) begin
                    state_nxt       = ROUND_INTRO;
                    lives_nxt       = 2'(START_LIVES);
                    round_nxt       = 2'd0;
                    game_won_nxt    = 1'b0;
                    round_reset_nxt = 1'b1;
                    frame_cnt_nxt   = '0;
                    invuln_nxt      = 1'b0;
                    invuln_cnt_nxt  = '0;
                end
            end

            ROUND_INTRO: begin
                invuln_nxt     = 1'b0;
                invuln_cnt_nxt = '0;
                if (frame_tick) begin
                    if (frame_cnt_inc == FW'(INTRO_FRAMES)) begin
                        state_nxt     = PLAY_GAME;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt_inc;
                    end
                end
            end

            PLAY_GAME: begin
                // Invulnerability window runs down on frame ticks; flag drops with the last count.
                if (frame_tick && (invuln_cnt_q != '0)) begin
                    invuln_cnt_nxt = invuln_cnt_q - FW'(1);
                    if (invuln_cnt_q == FW'(1)) begin
                        invuln_nxt = 1'b0;
                    end
                end

                if (aliens_invaded) begin
                    // Invasion ends the game regardless of lives left.
                    lives_nxt      = 2'd0;
                    game_won_nxt   = 1'b0;
                    state_nxt      = GAME_OVER;
                    frame_cnt_nxt  = '0;
                    invuln_nxt     = 1'b0;
                    invuln_cnt_nxt = '0;
                end else if (hit_live && (lives_remaining <= 2'd1)) begin
                    // Fatal hit; also suppresses any round clear this cycle and keeps lives at 0.
                    lives_nxt      = 2'd0;
                    game_won_nxt   = 1'b0;
                    state_nxt      = GAME_OVER;
                    frame_cnt_nxt  = '0;
                    invuln_nxt     = 1'b0;
                    invuln_cnt_nxt = '0;
                end else begin
                    if (hit_live) begin
                        lives_nxt      = lives_remaining - 2'd1;
                        invuln_nxt     = 1'b1;
                        invuln_cnt_nxt = FW'(INVULN_FRAMES);
                    end
                    // Clear is sampled only on frame ticks so the stale zero count right
                    // after a round_reset never looks like another clear.
                    if (frame_tick && (aliens_remaining == '0)) begin
                        frame_cnt_nxt  = '0;
                        invuln_nxt     = 1'b0;
                        invuln_cnt_nxt = '0;
                        if (current_round == 2'(NUM_ROUNDS - 1)) begin
                            game_won_nxt = 1'b1;
                            state_nxt    = GAME_OVER;
                        end else begin
                            round_nxt       = current_round + 2'd1;
                            round_reset_nxt = 1'b1;
                            state_nxt       = ROUND_INTRO;
                        end
                    end
                end
            end

            GAME_OVER: begin
                // Hold for the full count; start presses are not looked at until IDLE.
                if (frame_tick) begin
                    if (frame_cnt_inc == FW'(GAMEOVER_FRAMES)) begin
                        state_nxt     = IDLE;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt_inc;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            frame_cnt_q     <= '0;
            invuln_cnt_q    <= '0;
            current_round   <= 2'd0;
            lives_remaining <= 2'(START_LIVES);
            round_reset     <= 1'b0;
            invuln          <= 1'b0;
            game_won        <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            frame_cnt_q     <= frame_cnt_nxt;
            invuln_cnt_q    <= invuln_cnt_nxt;
            current_round   <= round_nxt;
            lives_remaining <= lives_nxt;
            round_reset     <= round_reset_nxt;
            invuln          <= invuln_nxt;
            game_won        <= game_won_nxt;
        end
    end

endmodule
